capture_frame_packer: RTL and testbench
=======================================

Name: capture_frame_packer

Overview:
- Sits in the pdh_clk domain between the pdh_core sample sources and the BRAM capture buffer.
- Decimates the paired ADC sample stream (channels A and B) by a runtime code.
- Packs two kept sample pairs into each 64-bit capture word and emits a write strobe with a sequential buffer address.
- Produces exactly one frame of FRAME_WORDS words per arm and signals completion, so the downstream DMA hand-off starts from a full buffer.

Parameters:
- ADC_DATA_WIDTH, 14, width of each input sample (two's complement).
- DEC_WIDTH, 22, width of the decimation code.
- ADDR_WIDTH, 11, width of the buffer word address.
- FRAME_WORDS, 2048, words per frame; must be 2..2**ADDR_WIDTH.

Ports:
- clk  in  1  pdh_clk, the only clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  level; a rising edge arms a capture; low aborts or clears.
- decimation_code_i  in  DEC_WIDTH  keep 1 of every (code+1) valid samples.
- sample_a_i  in  ADC_DATA_WIDTH  channel A sample.
- sample_b_i  in  ADC_DATA_WIDTH  channel B sample.
- sample_valid_i  in  1  sample_a_i and sample_b_i are valid this cycle.
- word_o  out  64  packed capture word.
- word_valid_o  out  1  one-cycle write strobe for word_o/waddr_o.
- waddr_o  out  ADDR_WIDTH  buffer word address.
- word_count_o  out  ADDR_WIDTH+1  words written in the current frame.
- busy_o  out  1  high in CAPTURE.
- done_o  out  1  frame complete.

Behaviour:
- Interface: one clock (clk). rst_i is synchronous and active-high.
- Reset: state IDLE; all outputs 0; decimation counter 0; half flag 0; enable edge register 0.
- States: IDLE, CAPTURE, DONE.
- IDLE -> CAPTURE on a rising edge of enable_i (enable_i=1 and previous value 0).
  - On entry, latch decimation_code_i.
  - Clear dec_cnt, half flag, word index and word_count_o.
- CAPTURE:
  - Each cycle with sample_valid_i=1: the sample is kept if dec_cnt==0; dec_cnt = (dec_cnt==code) ? 0 : dec_cnt+1.
  - Code 0 keeps every sample. Code 2**DEC_WIDTH-1 must not overflow the counter.
  - Samples are sign-extended to 16 bits.
  - First kept pair goes to word bits [63:48]=A and [47:32]=B; half flag is set.
  - Second kept pair goes to bits [31:16]=A and [15:0]=B.
  - On the second kept pair, word_valid_o=1 on the next cycle, with waddr_o=index and word_o holding the full word. Latency is exactly 1 cycle from the sample_valid_i edge.
  - Index and word_count_o increment in the same cycle as the strobe.
  - word_o and waddr_o hold their values between strobes.
  - Downstream always accepts; there is no backpressure.
- Changes to decimation_code_i during CAPTURE are ignored.
- CAPTURE -> DONE in the same cycle as the strobe for index FRAME_WORDS-1. busy_o drops and done_o rises on the cycle after that strobe.
- DONE: no further strobes; valid samples are ignored; done_o stays high while enable_i=1.
- DONE -> IDLE when enable_i=0; done_o clears on the next cycle.
- Abort: enable_i=0 in CAPTURE -> IDLE.
  - A partial half-word is discarded.
  - A strobe already scheduled in that cycle still completes.
  - done_o is not asserted.
  - word_count_o holds its value until the next arm.
- enable_i held high across DONE does not re-arm; a new rising edge is required.
- rst_i has priority over all events, including a strobe in flight.
- sample_valid_i in IDLE or DONE has no effect.

Decomposition:
- Package capture_pkg holds:
  - state enum cap_state_t (IDLE, CAPTURE, DONE);
  - word field offset constants (A0_HI=63, B0_HI=47, A1_HI=31, B1_HI=15);
  - function sext16() for sample sign extension.
- Sub-module sample_decimator (clk, rst_i, clear, code, valid_i -> keep_o) holds dec_cnt and the latched code. Its keep_o is combinational from dec_cnt and valid_i.

Test Plan:
1. Code 0, FRAME_WORDS=4, arm, then valid samples A=1..8 and B=-1..-8.
   - Expect 4 strobes at addresses 0..3.
   - Word 0 = 0x0001_FFFF_0002_FFFE.
   - done_o rises 1 cycle after the 4th strobe; busy_o falls in the same cycle.
2. Code 2, continuous valid, A=n.
   - Kept samples are n = 0, 3, 6, 9, ...
   - Word 0 has A0=0 and A1=3; word 1 has A0=6 and A1=9.
   - Change the code mid-frame: the kept pattern is unchanged.
3. Sparse valid: assert sample_valid_i every 3rd cycle with code 1.
   - Strobe appears exactly 1 cycle after every 4th valid sample.
   - word_o is stable between strobes.
4. Abort: deassert enable_i after 1.5 words.
   - Exactly 1 strobe; state returns to IDLE; done_o stays 0.
   - Re-arm: the next frame starts at waddr_o=0 with fresh packing, and the half-word is not reused.
5. Hold enable_i high after DONE for 100 cycles with valid samples.
   - No strobes; done_o stays 1.
   - Drop then raise enable_i: a new frame captures.
6. Assert rst_i mid-CAPTURE in the cycle a strobe is due.
   - No strobe; all outputs are 0 next cycle; state is IDLE.

Source files
------------

// File: rtl/capture_frame_packer_pkg.sv
// ============================================================================
// Module   : capture_pkg
// Brief    : Shared types, word field offsets and sample sign extension
//            for the capture frame packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    localparam int A0_HI = 63;
    localparam int B0_HI = 47;
    localparam int A1_HI = 31;
    localparam int B1_HI = 15;

    // msb is the sign bit position of the zero-padded input sample.
    function automatic logic [15:0] sext16(input logic [15:0] s, input logic [3:0] msb);
        logic [15:0] keep_mask;
        keep_mask = ~(16'hFFFE << msb);
        return s[msb] ? (s | ~keep_mask) : (s & keep_mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/capture_frame_packer_if.sv
// ============================================================================
// Module   : capture_frame_packer_if
// Brief    : Sample input bus and capture-buffer write bus of the packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface capture_frame_packer_if #(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int ADDR_WIDTH     = 11
);
    logic [ADC_DATA_WIDTH-1:0] sample_a_i;
    logic [ADC_DATA_WIDTH-1:0] sample_b_i;
    logic                      sample_valid_i;
    logic [63:0]               word_o;
    logic                      word_valid_o;
    logic [ADDR_WIDTH-1:0]     waddr_o;

    modport master (
        input  sample_a_i,
        input  sample_b_i,
        input  sample_valid_i,
        output word_o,
        output word_valid_o,
        output waddr_o
    );

    modport slave (
        output sample_a_i,
        output sample_b_i,
        output sample_valid_i,
        input  word_o,
        input  word_valid_o,
        input  waddr_o
    );
endinterface

`default_nettype wire

// File: rtl/capture_frame_packer_decimator.sv
// ============================================================================
// Module   : sample_decimator
// Brief    : Keeps one of every (code+1) valid samples; code latched on clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_decimator #(
    parameter int DEC_WIDTH = 22
) (
    input  wire logic                 clk,
    input  wire logic                 rst_i,
    input  wire logic                 clear,
    input  wire logic [DEC_WIDTH-1:0] code,
    input  wire logic                 valid_i,
    output logic                      keep_o
);

    logic [DEC_WIDTH-1:0] r_code;
    logic [DEC_WIDTH-1:0] r_cnt;

    // Wrapping on equality rather than on overflow keeps the all-ones code safe.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_code <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_code <= code;
            r_cnt  <= '0;
        end else if (valid_i) begin
            r_cnt <= (r_cnt == r_code) ? '0 : r_cnt + DEC_WIDTH'(1);
        end
    end

    assign keep_o = valid_i && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/capture_frame_packer.sv
// ============================================================================
// Module   : capture_frame_packer
// Brief    : Decimates paired ADC samples and packs them into one frame of
//            64-bit capture words with sequential buffer addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_frame_packer
    import capture_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int DEC_WIDTH      = 22,
    parameter int ADDR_WIDTH     = 11,
    parameter int FRAME_WORDS    = 2048
) (
    input  wire logic                  clk,
    input  wire logic                  rst_i,
    input  wire logic                  enable_i,
    input  wire logic [DEC_WIDTH-1:0]  decimation_code_i,
    capture_frame_packer_if.master     bus,
    output logic [ADDR_WIDTH:0]        word_count_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [3:0]            c_SIGN_MSB  = 4'(ADC_DATA_WIDTH - 1);

    cap_state_t             r_state;
    cap_state_t             w_next_state;
    logic                   r_en_d;
    logic                   r_half;
    logic [31:0]            r_hi;
    logic [63:0]            r_word;
    logic                   r_wvalid;
    logic [ADDR_WIDTH-1:0]  r_waddr;
    logic [ADDR_WIDTH-1:0]  r_index;
    logic [ADDR_WIDTH:0]    r_count;

    logic                   w_rise;
    logic                   w_arm;
    logic                   w_take;
    logic                   w_keep;
    logic                   w_last_strobe;
    logic [15:0]            w_a16;
    logic [15:0]            w_b16;

    assign w_rise        = enable_i && !r_en_d;
    assign w_arm         = (r_state == IDLE) && w_rise;
    assign w_take        = (r_state == CAPTURE) && enable_i && bus.sample_valid_i;
    assign w_last_strobe = r_wvalid && (r_waddr == c_LAST_ADDR);
    assign w_a16         = sext16(16'(bus.sample_a_i), c_SIGN_MSB);
    assign w_b16         = sext16(16'(bus.sample_b_i), c_SIGN_MSB);

    sample_decimator #(
        .DEC_WIDTH (DEC_WIDTH)
    ) u_decimator (
        .clk     (clk),
        .rst_i   (rst_i),
        .clear   (w_arm),
        .code    (decimation_code_i),
        .valid_i (w_take),
        .keep_o  (w_keep)
    );

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The frame ends in the cycle its final strobe is presented, so status
    // outputs follow one cycle after that strobe.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!enable_i) begin
                    w_next_state = IDLE;
                end else if (w_last_strobe) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (!enable_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_en_d   <= 1'b0;
            r_half   <= 1'b0;
            r_hi     <= '0;
            r_word   <= '0;
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_index  <= '0;
            r_count  <= '0;
        end else begin
            r_en_d   <= enable_i;
            r_wvalid <= 1'b0;
            if (w_arm) begin
                r_half  <= 1'b0;
                r_index <= '0;
                r_count <= '0;
            end else if (w_keep) begin
                if (!r_half) begin
                    r_hi   <= {w_a16, w_b16};
                    r_half <= 1'b1;
                end else begin
                    r_word[A0_HI -: 16] <= r_hi[31:16];
                    r_word[B0_HI -: 16] <= r_hi[15:0];
                    r_word[A1_HI -: 16] <= w_a16;
                    r_word[B1_HI -: 16] <= w_b16;
                    r_wvalid <= 1'b1;
                    r_waddr  <= r_index;
                    r_index  <= r_index + ADDR_WIDTH'(1);
                    r_count  <= r_count + (ADDR_WIDTH+1)'(1);
                    r_half   <= 1'b0;
                end
            end
        end
    end

    assign bus.word_o       = r_word;
    assign bus.word_valid_o = r_wvalid;
    assign bus.waddr_o      = r_waddr;
    assign word_count_o     = r_count;
    assign busy_o           = (r_state == CAPTURE);
    assign done_o           = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_capture_frame_packer.sv
// ============================================================================
// Module   : tb_capture_frame_packer
// Brief    : Scoreboard bench for capture_frame_packer with a 4-word frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_capture_frame_packer;

    localparam int ADW = 14;
    localparam int DW  = 22;
    localparam int AW  = 11;
    localparam int FW  = 4;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [63:0] word;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            enable_i = 1'b0;
    logic [DW-1:0]   decimation_code_i = '0;
    logic [AW:0]     word_count_o;
    logic            busy_o;
    logic            done_o;

    capture_frame_packer_if #(.ADC_DATA_WIDTH(ADW), .ADDR_WIDTH(AW)) bus ();

    capture_frame_packer #(
        .ADC_DATA_WIDTH (ADW),
        .DEC_WIDTH      (DW),
        .ADDR_WIDTH     (AW),
        .FRAME_WORDS    (FW)
    ) dut (
        .clk               (clk),
        .rst_i             (rst_i),
        .enable_i          (enable_i),
        .decimation_code_i (decimation_code_i),
        .bus               (bus.master),
        .word_count_o      (word_count_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    logic [63:0] got [0:FW-1];
    logic [63:0] last_word = '0;
    logic [AW-1:0] last_addr = '0;

    // Bench decimation/packing model state
    bit          m_active = 0;
    int          m_code = 0;
    int          m_cnt = 0;
    bit          m_half = 0;
    logic [31:0] m_hi = '0;
    int          m_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] s16(input int v);
        logic [13:0] t;
        t = v[13:0];
        return {{2{t[13]}}, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit v, input int a, input int b);
        bit keep;
        bus.sample_valid_i = v;
        bus.sample_a_i     = a[ADW-1:0];
        bus.sample_b_i     = b[ADW-1:0];
        if (v && m_active) begin
            keep  = (m_cnt == 0);
            m_cnt = (m_cnt == m_code) ? 0 : m_cnt + 1;
            if (keep) begin
                if (!m_half) begin
                    m_hi   = {s16(a), s16(b)};
                    m_half = 1;
                end else begin
                    q.push_back('{cyc: cyc + 1, addr: AW'(m_idx), word: {m_hi, s16(a), s16(b)}});
                    m_idx++;
                    m_half = 0;
                    if (m_idx == FW) m_active = 0;
                end
            end
        end
        tick();
    endtask

    task automatic arm(input int code, input bit model_on);
        bus.sample_valid_i = 1'b0;
        enable_i = 1'b0;
        tick();
        decimation_code_i = DW'(code);
        enable_i = 1'b1;
        tick();
        m_active = model_on;
        m_code = code;
        m_cnt = 0;
        m_half = 0;
        m_idx = 0;
        chk("arm_busy", 64'(busy_o), 64'd1);
    endtask

    // Monitor: pops the scoreboard on each strobe and checks hold between strobes.
    always @(negedge clk) begin
        if (rst_i) begin
            last_word = '0;
            last_addr = '0;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_strobe: got none expected addr %0d word %h at cycle %0d",
                         q[0].addr, q[0].word, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.word_valid_o) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got addr %0d word %h expected no strobe (cycle %0d)",
                             bus.waddr_o, bus.word_o, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    chk("strobe_addr", 64'(bus.waddr_o), 64'(e.addr));
                    chk("strobe_word", bus.word_o, e.word);
                end
                if (bus.waddr_o < AW'(FW)) got[bus.waddr_o] = bus.word_o;
                last_word = bus.word_o;
                last_addr = bus.waddr_o;
            end else begin
                chk("hold_word", bus.word_o, last_word);
                chk("hold_addr", 64'(bus.waddr_o), 64'(last_addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0] T1_WORDS [0:3] = '{
        64'h0001_FFFF_0002_FFFE, 64'h0003_FFFD_0004_FFFC,
        64'h0005_FFFB_0006_FFFA, 64'h0007_FFF9_0008_FFF8
    };

    initial begin
        bus.sample_valid_i = 1'b0;
        bus.sample_a_i = '0;
        bus.sample_b_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        chk("rst_word", bus.word_o, 64'd0);
        chk("rst_valid", 64'(bus.word_valid_o), 64'd0);
        chk("rst_addr", 64'(bus.waddr_o), 64'd0);
        chk("rst_count", 64'(word_count_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);

        // 1: code 0, hand-computed words
        arm(0, 0);
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 0) q.push_back('{cyc: cyc + 1, addr: AW'(i/2 - 1), word: T1_WORDS[i/2 - 1]});
            send(1, i, -i);
        end
        chk("t1_busy_at_last", 64'(busy_o), 64'd1);
        chk("t1_done_at_last", 64'(done_o), 64'd0);
        tick();
        chk("t1_busy_after", 64'(busy_o), 64'd0);
        chk("t1_done_after", 64'(done_o), 64'd1);
        chk("t1_count", 64'(word_count_o), 64'd4);

        // 2: code 2, code changed mid-frame
        arm(2, 1);
        for (int n = 0; n < 24; n++) begin
            if (n == 8) decimation_code_i = DW'(5);
            send(1, n, n + 100);
        end
        tick();
        chk("t2_w0_a0", 64'(got[0][63:48]), 64'd0);
        chk("t2_w0_a1", 64'(got[0][31:16]), 64'd3);
        chk("t2_w1_a0", 64'(got[1][63:48]), 64'd6);
        chk("t2_w1_a1", 64'(got[1][31:16]), 64'd9);
        chk("t2_w3_b1", 64'(got[3][15:0]), 64'd121);
        chk("t2_done", 64'(done_o), 64'd1);

        // 3: sparse valid, code 1
        arm(1, 1);
        for (int k = 0; k < 16; k++) begin
            send(1, k, -k - 20);
            send(0, 0, 0);
            send(0, 0, 0);
        end
        chk("t3_done", 64'(done_o), 64'd1);

        // 4: abort after 1.5 words, then re-arm
        arm(0, 1);
        send(1, 1, -1);
        send(1, 2, -2);
        m_active = 0;
        enable_i = 1'b0;
        send(1, 3, -3);
        chk("t4_busy", 64'(busy_o), 64'd0);
        chk("t4_done", 64'(done_o), 64'd0);
        chk("t4_count", 64'(word_count_o), 64'd1);
        repeat (3) tick();
        chk("t4_done_later", 64'(done_o), 64'd0);
        arm(0, 1);
        for (int i = 10; i < 14; i++) send(1, i, i);
        chk("t4_rearm_a0", 64'(got[0][63:48]), 64'd10);
        chk("t4_rearm_count", 64'(word_count_o), 64'd2);
        enable_i = 1'b0;
        tick();

        // 5: enable held high in DONE
        arm(0, 1);
        for (int i = 0; i < 8; i++) send(1, i, i);
        for (int i = 0; i < 100; i++) begin
            send(1, 50 + i, i);
            if (i % 25 == 24) chk("t5_done_hold", 64'(done_o), 64'd1);
        end
        enable_i = 1'b0;
        tick();
        chk("t5_done_clear", 64'(done_o), 64'd0);
        arm(0, 1);
        for (int i = 0; i < 8; i++) send(1, 200 + i, -i);
        tick();
        chk("t5_second_done", 64'(done_o), 64'd1);

        // 6: reset when a strobe is due
        arm(0, 1);
        send(1, 5, 5);
        m_active = 0;
        rst_i = 1'b1;
        send(1, 6, 6);
        rst_i = 1'b0;
        enable_i = 1'b0;
        bus.sample_valid_i = 1'b0;
        chk("t6_valid", 64'(bus.word_valid_o), 64'd0);
        chk("t6_word", bus.word_o, 64'd0);
        chk("t6_addr", 64'(bus.waddr_o), 64'd0);
        chk("t6_count", 64'(word_count_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_done", 64'(done_o), 64'd0);

        repeat (4) tick();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
